// File: rtl/imem_fetch_port.sv
// imem_fetch_port: registered instruction memory with valid/ready fetch port, wait states and paired-word reads
// Optional feature: define IMEM_IVT_LOCK_EN to write-protect words [0, IVT_WORDS-1] and report rejected writes on wr_err.
module imem_fetch_port #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 20,
    parameter int IVT_WORDS   = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [31:0]         req_addr,
    input  logic                req_pair,
    output logic                rsp_valid,
    output logic [2*DATA_W-1:0] rsp_data,
    output logic                rsp_pair,
    input  logic                wr_en,
    input  logic [31:0]         wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                wr_err,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [3:0]        WS  = 4'(WAIT_STATES);
    localparam logic [ADDR_W-1:0] IVT = ADDR_W'(IVT_WORDS);
    state_t            state;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] addr_q, rd_addr, rd_addr2;
    logic [3:0]        cnt;
    logic              pair_q, accept, enter_resp, rd_pair, wr_ok, unused;
    assign req_ready  = !rst && state != WAIT;
    assign accept     = req_valid && req_ready;
    assign busy       = state == WAIT;
    assign rsp_valid  = state == RESP;
    assign enter_resp = (accept && WS == 4'd0) || (state == WAIT && cnt == 4'd1);
    assign rd_addr    = accept ? req_addr[ADDR_W-1:0] : addr_q;
    assign rd_addr2   = rd_addr + 1'b1;
    assign rd_pair    = accept ? req_pair : pair_q;
`ifdef IMEM_IVT_LOCK_EN
    assign wr_ok  = wr_addr[ADDR_W-1:0] >= IVT;
    assign unused = ^{req_addr[31:ADDR_W], wr_addr[31:ADDR_W]};
    // flag loader writes that hit the protected vector area
    always_ff @(posedge clk) wr_err <= !rst && wr_en && !wr_ok;
`else
    assign wr_ok  = 1'b1;
    assign wr_err = 1'b0;
    assign unused = ^{req_addr[31:ADDR_W], wr_addr[31:ADDR_W], IVT};
`endif
    // loader write port, independent of the fetch FSM and of rst; NBA gives read-before-write on collisions
    always_ff @(posedge clk)
        if (wr_en && wr_ok) mem[wr_addr[ADDR_W-1:0]] <= wr_data;
    // fetch FSM: capture request, count wait states, read memory on the edge entering RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            pair_q   <= 1'b0;
            cnt      <= '0;
            rsp_data <= '0;
            rsp_pair <= 1'b0;
        end else begin
            if (enter_resp) begin
                rsp_data <= {rd_pair ? mem[rd_addr2] : {DATA_W{1'b0}}, mem[rd_addr]};
                rsp_pair <= rd_pair;
            end
            if (accept) begin
                addr_q <= req_addr[ADDR_W-1:0];
                pair_q <= req_pair;
                cnt    <= WS;
                state  <= WS == 4'd0 ? RESP : WAIT;
            end else if (state == WAIT) begin
                cnt   <= cnt - 4'd1;
                state <= cnt == 4'd1 ? RESP : WAIT;
            end else if (state == RESP) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: doc/imem_fetch_port.md
# imem_fetch_port

Parametrised, registered instruction memory for the fetch stage, with a valid/ready request port, configurable wait states, and single-word or paired-word fetches. A paired fetch returns an opcode word and its immediate word together. A separate synchronous write port serves the loader, and interrupt-vector words can be write-protected. It sits between the PC logic and the fetch/decode pipeline register.

## Interface
- DATA_W, 16, instruction word width
- ADDR_W, 20, word-address width; depth = 2^ADDR_W
- IVT_WORDS, 32, size of the interrupt-vector area at words [0, IVT_WORDS-1]
- WAIT_STATES, 0, extra cycles per read (0-15)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  fetch request
- req_ready  out  1  request accepted when req_valid && req_ready
- req_addr  in  32  word address; only [ADDR_W-1:0] used
- req_pair  in  1  1 = fetch words addr and addr+1
- rsp_valid  out  1  one-cycle pulse, response data valid
- rsp_data  out  2*DATA_W  [DATA_W-1:0] = word at addr; upper half = word at addr+1 (pair) or 0
- rsp_pair  out  1  echo of req_pair for this response
- wr_en  in  1  loader write strobe
- wr_addr  in  32  write word address; only [ADDR_W-1:0] used
- wr_data  in  DATA_W  write data
- wr_err  out  1  one-cycle pulse, write rejected
- busy  out  1  request in flight (WAIT state)

## Operation
- FSM states: IDLE, WAIT, RESP.
- Accept: the request is captured on the edge where req_valid && req_ready. Captured fields are addr, pair, and a wait counter loaded with WAIT_STATES.
  - WAIT_STATES == 0: go to RESP.
  - Otherwise: go to WAIT.
- WAIT: counter decrements each cycle. Move to RESP on the edge where counter == 1.
- Memory read: occurs on the edge that enters RESP. rsp_data and rsp_pair are registered there. In RESP, rsp_valid = 1.
- RESP exit:
  - Back to IDLE by default.
  - If a new request is accepted in RESP, go directly to WAIT or RESP as above.
- req_ready = 1 in IDLE and RESP; 0 in WAIT and during rst.
- Pair address: second word address = (addr + 1) mod 2^ADDR_W. Address 2^ADDR_W-1 pairs with word 0.
- Non-pair fetch: upper half of rsp_data = 0.
- Writes: wr_en writes mem[wr_addr[ADDR_W-1:0]] on the rising edge. Writes are independent of the FSM and accepted in any state, including during rst.
- Read/write collision: a write on the same edge as the read edge, to the same address, does not affect that response (read-before-write). The new value is visible to later reads.
- Memory contents are not cleared by rst.

## Timing
- Reset values: req_ready 0 while rst is high, 1 on the first cycle after; rsp_valid 0, rsp_data 0, rsp_pair 0, busy 0, wr_err 0, state IDLE.
- Latency: request accepted at edge N → rsp_valid high in cycle N+1+WAIT_STATES.
- Throughput: one response per 1+WAIT_STATES cycles with continuous req_valid. With WAIT_STATES = 0, rsp_valid is high every cycle.
- rsp_data holds its last value after rsp_valid drops.
- rst asserted mid-request (WAIT or RESP): the in-flight request is dropped and no rsp_valid is produced. A response already in RESP is killed in the cycle after the rst edge.
- wr_err pulses in the cycle after the rejected write edge.

## Configuration
- IMEM_IVT_LOCK_EN defined:
  - Writes with wr_addr[ADDR_W-1:0] < IVT_WORDS are discarded and memory is unchanged.
  - wr_err pulses high for one cycle.
  - Writes at or above IVT_WORDS behave normally.
- IMEM_IVT_LOCK_EN undefined: all writes land and wr_err is tied 0.

## Test plan
- Basic read, WAIT_STATES=0: write mem[32]=16'hD020, then request addr 32, pair=0 → rsp_valid one cycle later, rsp_data=32'h0000D020, rsp_pair=0.
- Paired read with wait states, WAIT_STATES=3: mem[40]=16'hD040, mem[41]=16'h0002; request addr 40, pair=1 → busy high 3 cycles, req_ready low 3 cycles, rsp_valid 4 cycles after accept, rsp_data=32'h0002D040.
- Wrap and truncation: mem[2^20-1]=16'hAAAA, mem[0]=16'h5555; pair request at req_addr 32'h00FFFFFF → rsp_data=32'h5555AAAA.
- Back-to-back, WAIT_STATES=0: req_valid held high for addresses 32, 33, 34 → three consecutive rsp_valid cycles in order; write 16'h1111 to addr 33 on its read edge → response for 33 shows the old value.
- Reset mid-request, WAIT_STATES=5: rst pulsed 2 cycles after accept → no rsp_valid ever; after release req_ready=1, busy=0, and a new request completes normally.
- IVT lock, IMEM_IVT_LOCK_EN defined: write 16'hFFFF to addr 5 → wr_err pulse, read of addr 5 returns the prior value. Write to addr 32 → no wr_err, value stored. With the macro undefined, addr 5 is written and wr_err stays 0.
